// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and constants for the iterative divide sequencer.
//   - thread count and derived widths
//   - divide opcodes and the divide-by-zero trap type
//   - request/response records and the sequencer state enum
package div_sched_pkg;

    localparam int NTHREAD = 64;
    localparam int TIDW    = $clog2(NTHREAD);
    localparam int CNTW    = $clog2(NTHREAD + 1);

    localparam logic [5:0] UDIV    = 6'h0e;
    localparam logic [5:0] SDIV    = 6'h0f;
    localparam logic [5:0] UDIVCC  = 6'h1e;
    localparam logic [5:0] SDIVCC  = 6'h1f;
    localparam logic [5:0] TT_DIVZ = 6'h2a;

    typedef logic [TIDW-1:0] tid_t;

    typedef struct packed {
        tid_t        tid;
        logic [5:0]  op3;
        logic [31:0] y;
        logic [31:0] rs1;
        logic [31:0] op2;
        logic        live;
    } div_req_type;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ITER,
        FIX,
        DONE
    } div_state_type;

    typedef struct packed {
        tid_t        tid;
        logic [31:0] result;
        logic [3:0]  icc;
        logic        icc_we;
        logic        trap;
        logic [5:0]  tt;
    } div_resp_type;

    function automatic logic is_div_op(input logic [5:0] op3);
        return (op3 == UDIV) || (op3 == SDIV) || (op3 == UDIVCC) || (op3 == SDIVCC);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] op3);
        return (op3 == SDIV) || (op3 == SDIVCC);
    endfunction

    function automatic logic is_cc_op(input logic [5:0] op3);
        return (op3 == UDIVCC) || (op3 == SDIVCC);
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// div_req_fifo: circular request queue with a per-entry live bit.
//   gclk, rstn       clock, asynchronous active-low reset
//   push, push_data  enqueue one request (caller guarantees not full)
//   pop              dequeue the head (caller guarantees not empty)
//   kill, kill_tid   clear the live bit of every entry owned by kill_tid
//   head             head entry; live already reflects a same-cycle kill
//   count            number of occupied entries
module div_req_fifo
    import div_sched_pkg::*;
(
    input  logic            gclk,
    input  logic            rstn,
    input  logic            push,
    input  div_req_type     push_data,
    input  logic            pop,
    input  logic            kill,
    input  tid_t            kill_tid,
    output div_req_type     head,
    output logic [CNTW-1:0] count
);

    localparam tid_t PTR_LAST = tid_t'(NTHREAD - 1);

    div_req_type        mem [NTHREAD];
    logic [NTHREAD-1:0] live;
    tid_t               head_ptr;
    tid_t               tail_ptr;

    function automatic tid_t ptr_next(input tid_t p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A kill in the current cycle must already hide the head, so the
    // sequencer never starts work that is being flushed right now.
    always_comb begin
        head      = mem[head_ptr];
        head.live = (count != '0) && live[head_ptr] &&
                    !(kill && (mem[head_ptr].tid == kill_tid));
    end

    // NOTE: payload storage has no reset; only the live bits and pointers
    // define validity, so resetting the array would only cost logic.
    always_ff @(posedge gclk) begin
        if (push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            live     <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            for (int i = 0; i < NTHREAD; i++) begin
                if (kill && (mem[i].tid == kill_tid)) begin
                    live[i] <= 1'b0;
                end
            end
            // Written after the kill loop so the fresh entry's own live bit wins.
            if (push) begin
                live[tail_ptr] <= push_data.live;
                tail_ptr       <= ptr_next(tail_ptr);
            end
            if (pop) begin
                head_ptr <= ptr_next(head_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/div_sched.sv
// div_sched: per-thread queued, shared 32-step restoring divider.
//   gclk, rstn                         clock, asynchronous active-low reset
//   req_valid/req_ready                request handshake (ready = queue not full)
//   req_tid, req_op3, req_y,
//   req_rs1, req_op2                   thread, opcode, dividend {y,rs1}, divisor
//   flush, flush_tid                   kill queued and in-flight work of a thread
//   resp_valid/resp_ready              response handshake
//   resp_tid, resp_result, resp_icc,
//   resp_icc_we, resp_trap, resp_tt    registered response fields
//   busy                               sequencer active or queue non-empty
module div_sched
    import div_sched_pkg::*;
(
    input  logic             gclk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TIDW-1:0]  req_tid,
    input  logic [5:0]       req_op3,
    input  logic [31:0]      req_y,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_op2,
    input  logic             flush,
    input  logic [TIDW-1:0]  flush_tid,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TIDW-1:0]  resp_tid,
    output logic [31:0]      resp_result,
    output logic [3:0]       resp_icc,
    output logic             resp_icc_we,
    output logic             resp_trap,
    output logic [5:0]       resp_tt,
    output logic             busy
);

    localparam logic [CNTW-1:0] FIFO_FULL = CNTW'(NTHREAD);

    div_state_type    state;
    tid_t             cur_tid;
    logic [5:0]       cur_op3;
    logic [31:0]      rem;      // dividend high, then partial remainder
    logic [31:0]      quo;      // dividend low, then quotient
    logic [31:0]      dvsr;
    logic [4:0]       cnt;
    logic             neg;
    logic             ovf;
    logic             trap;
    div_resp_type     resp_q;

    div_req_type      head;
    div_req_type      push_data;
    logic [CNTW-1:0]  fifo_count;
    logic             push;
    logic             pop;
    logic             kill_cur;
    logic             op_signed;

    // ---------------- queue ----------------
    assign req_ready = (fifo_count != FIFO_FULL);
    assign push      = req_valid && req_ready && is_div_op(req_op3);
    assign kill_cur  = flush && (state != IDLE) && (cur_tid == flush_tid);
    assign op_signed = is_signed_op(cur_op3);
    assign busy      = (state != IDLE) || (fifo_count != '0);

    // A request killed in its own accept cycle still occupies a slot but is
    // born dead, so IDLE discards it like any other flushed entry.
    always_comb begin
        push_data.tid  = req_tid;
        push_data.op3  = req_op3;
        push_data.y    = req_y;
        push_data.rs1  = req_rs1;
        push_data.op2  = req_op2;
        push_data.live = !(flush && (flush_tid == req_tid));
    end

    // IDLE pops every head (dead ones are dropped); DONE pops only a live
    // head so the next divide can go straight to SETUP.
    assign pop = (fifo_count != '0) &&
                 ((state == IDLE) ||
                  ((state == DONE) && resp_ready && !kill_cur && head.live));

    div_req_fifo u_fifo (
        .gclk      (gclk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .kill      (flush),
        .kill_tid  (flush_tid),
        .head      (head),
        .count     (fifo_count)
    );

    // ---------------- SETUP: magnitudes, sign, overflow ----------------
    logic [63:0] dividend;
    logic [63:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic        setup_sign;
    logic        setup_ovf;

    always_comb begin
        // NOTE: every signal of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        dividend = {rem, quo};
        dvd_mag  = dividend;
        dvs_mag  = dvsr;
        if (op_signed && dividend[63]) dvd_mag = -dividend;
        if (op_signed && dvsr[31])     dvs_mag = -dvsr;
        setup_sign = op_signed && (dividend[63] ^ dvsr[31]);
        // Quotient would need more than 32 bits.
        setup_ovf  = (dvd_mag[63:32] >= dvs_mag);
    end

    // ---------------- ITER: one restoring step ----------------
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvsr};
        if (!diff[32]) begin
            step_rem = diff[31:0];
            step_quo = {quo[30:0], 1'b1};
        end else begin
            step_rem = shifted[31:0];
            step_quo = {quo[30:0], 1'b0};
        end
    end

    // ---------------- FIX: sign, saturation, flags ----------------
    div_resp_type fix_resp;
    logic [31:0]  res;
    logic         sat_v;

    always_comb begin
        res   = quo;
        sat_v = 1'b0;
        if (!op_signed) begin
            if (ovf) begin
                res   = 32'hffff_ffff;
                sat_v = 1'b1;
            end
        end else if (neg) begin
            // Magnitude 2^31 is still representable as a negative result.
            if (ovf || (quo > 32'h8000_0000)) begin
                res   = 32'h8000_0000;
                sat_v = 1'b1;
            end else begin
                res = -quo;
            end
        end else if (ovf || quo[31]) begin
            res   = 32'h7fff_ffff;
            sat_v = 1'b1;
        end

        fix_resp     = '0;
        fix_resp.tid = cur_tid;
        if (trap) begin
            fix_resp.trap = 1'b1;
            fix_resp.tt   = TT_DIVZ;
        end else begin
            fix_resp.result = res;
            fix_resp.icc    = {res[31], (res == 32'h0), sat_v, 1'b0};
            fix_resp.icc_we = is_cc_op(cur_op3);
        end
    end

    // ---------------- sequencer ----------------
    // NOTE: state is updated with non-blocking assignments only, so every
    // register in this block sees the pre-edge values of all the others.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cur_tid    <= '0;
            cur_op3    <= '0;
            rem        <= '0;
            quo        <= '0;
            dvsr       <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            ovf        <= 1'b0;
            trap       <= 1'b0;
            resp_q     <= '0;
            resp_valid <= 1'b0;
        end else if (kill_cur) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop && head.live) begin
                        cur_tid <= head.tid;
                        cur_op3 <= head.op3;
                        rem     <= head.y;
                        quo     <= head.rs1;
                        dvsr    <= head.op2;
                        neg     <= 1'b0;
                        ovf     <= 1'b0;
                        trap    <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (dvsr == 32'h0) begin
                        trap  <= 1'b1;
                        state <= FIX;
                    end else begin
                        rem  <= dvd_mag[63:32];
                        quo  <= dvd_mag[31:0];
                        dvsr <= dvs_mag;
                        neg  <= setup_sign;
                        if (setup_ovf) begin
                            ovf   <= 1'b1;
                            state <= FIX;
                        end else begin
                            cnt   <= 5'd31;
                            state <= ITER;
                        end
                    end
                end
                ITER: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (cnt == 5'd0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    resp_q     <= fix_resp;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (pop) begin
                            cur_tid <= head.tid;
                            cur_op3 <= head.op3;
                            rem     <= head.y;
                            quo     <= head.rs1;
                            dvsr    <= head.op2;
                            neg     <= 1'b0;
                            ovf     <= 1'b0;
                            trap    <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_tid    = resp_q.tid;
    assign resp_result = resp_q.result;
    assign resp_icc    = resp_q.icc;
    assign resp_icc_we = resp_q.icc_we;
    assign resp_trap   = resp_q.trap;
    assign resp_tt     = resp_q.tt;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: self-checking bench for div_sched.
//   Directed vector table, hand-written ordering/flush/reset sequences, and
//   randomized divides checked against an arithmetic reference model.
module tb_div_sched;
    import div_sched_pkg::*;

    logic             gclk = 1'b0;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [TIDW-1:0]  req_tid;
    logic [5:0]       req_op3;
    logic [31:0]      req_y;
    logic [31:0]      req_rs1;
    logic [31:0]      req_op2;
    logic             flush;
    logic [TIDW-1:0]  flush_tid;
    logic             resp_valid;
    logic             resp_ready;
    logic [TIDW-1:0]  resp_tid;
    logic [31:0]      resp_result;
    logic [3:0]       resp_icc;
    logic             resp_icc_we;
    logic             resp_trap;
    logic [5:0]       resp_tt;
    logic             busy;

    div_sched dut (
        .gclk        (gclk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_tid     (req_tid),
        .req_op3     (req_op3),
        .req_y       (req_y),
        .req_rs1     (req_rs1),
        .req_op2     (req_op2),
        .flush       (flush),
        .flush_tid   (flush_tid),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_tid    (resp_tid),
        .resp_result (resp_result),
        .resp_icc    (resp_icc),
        .resp_icc_we (resp_icc_we),
        .resp_trap   (resp_trap),
        .resp_tt     (resp_tt),
        .busy        (busy)
    );

    always #5 gclk = ~gclk;

    int cyc = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] result;
        logic [3:0]  icc;
        logic        icc_we;
        logic        trap;
        logic [5:0]  tt;
        int          lat;     // cycles from accept to resp_valid
    } exp_t;

    typedef struct {
        logic [5:0]  op3;
        logic [31:0] y;
        logic [31:0] rs1;
        logic [31:0] op2;
        exp_t        e;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: exact quotient from wide arithmetic, then clamp.
    function automatic exp_t model(input logic [5:0] op3, input logic [31:0] y,
                                   input logic [31:0] rs1, input logic [31:0] op2);
        exp_t               e;
        logic [63:0]        uq;
        logic signed [65:0] dd;
        logic signed [65:0] dv;
        logic signed [65:0] qq;
        logic signed [65:0] aq;
        logic [31:0]        r;
        logic               v;
        e.icc_we = (op3 == UDIVCC) || (op3 == SDIVCC);
        e.trap   = 1'b0;
        e.tt     = 6'h0;
        if (op2 == 32'h0) begin
            e.trap   = 1'b1;
            e.tt     = TT_DIVZ;
            e.result = 32'h0;
            e.icc    = 4'h0;
            e.icc_we = 1'b0;
            e.lat    = 4;
            return e;
        end
        if ((op3 == UDIV) || (op3 == UDIVCC)) begin
            uq    = {y, rs1} / {32'h0, op2};
            e.lat = (uq > 64'hffff_ffff) ? 4 : 36;
            if (uq > 64'hffff_ffff) begin r = 32'hffff_ffff; v = 1'b1; end
            else                    begin r = uq[31:0];      v = 1'b0; end
        end else begin
            dd    = {{2{y[31]}}, y, rs1};
            dv    = {{34{op2[31]}}, op2};
            qq    = dd / dv;
            aq    = (qq < 0) ? -qq : qq;
            e.lat = (aq >= 66'sh1_0000_0000) ? 4 : 36;
            if (qq > 66'sd2147483647)       begin r = 32'h7fff_ffff; v = 1'b1; end
            else if (qq < -66'sd2147483648) begin r = 32'h8000_0000; v = 1'b1; end
            else                            begin r = qq[31:0];      v = 1'b0; end
        end
        e.result = r;
        e.icc    = {r[31], (r == 32'h0), v, 1'b0};
        return e;
    endfunction

    function automatic vec_t mk(input logic [5:0] op3, input logic [31:0] y,
                                input logic [31:0] rs1, input logic [31:0] op2,
                                input logic [31:0] res, input logic [3:0] icc,
                                input logic we, input logic trap, input int lat);
        vec_t t;
        t.op3 = op3; t.y = y; t.rs1 = rs1; t.op2 = op2;
        t.e.result = res; t.e.icc = icc; t.e.icc_we = we; t.e.trap = trap;
        t.e.tt  = trap ? TT_DIVZ : 6'h0;
        t.e.lat = lat;
        return t;
    endfunction

    // Drive one request for one cycle; acc = cycle counter just after accept.
    task automatic send(input int tid, input logic [5:0] op3, input logic [31:0] y,
                        input logic [31:0] rs1, input logic [31:0] op2, output int acc);
        @(negedge gclk);
        req_tid = TIDW'(tid); req_op3 = op3; req_y = y; req_rs1 = rs1; req_op2 = op2;
        req_valid = 1'b1;
        @(posedge gclk);
        #1;
        req_valid = 1'b0;
        acc = cyc;
    endtask

    // Returns at the negedge where resp_valid is first seen.
    task automatic wait_resp(input string name, output int seen, output bit got);
        got  = 1'b0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge gclk);
            if (resp_valid) begin
                got  = 1'b1;
                seen = cyc;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL %s: resp_valid timeout after 200 cycles", name);
    endtask

    task automatic check_resp(input string name, input int tid, input exp_t e);
        check({name, ".tid"},    64'(resp_tid),    64'(tid));
        check({name, ".result"}, 64'(resp_result), 64'(e.result));
        if (!e.trap) check({name, ".icc"}, 64'(resp_icc), 64'(e.icc));
        check({name, ".icc_we"}, 64'(resp_icc_we), 64'(e.icc_we));
        check({name, ".trap"},   64'(resp_trap),   64'(e.trap));
        check({name, ".tt"},     64'(resp_tt),     64'(e.tt));
    endtask

    task automatic handshake(output int hs);
        resp_ready = 1'b1;
        @(posedge gclk);
        #1;
        resp_ready = 1'b0;
        hs = cyc;
    endtask

    vec_t       vecs [10];
    logic [5:0] ops [4] = '{UDIV, SDIV, UDIVCC, SDIVCC};

    initial begin
        int   acc, seen, hs, tid, nvalid;
        bit   got;
        exp_t e;
        logic [5:0]  op3;
        logic [31:0] y, rs1, op2;

        vecs[0] = mk(UDIV,   32'h0,        32'd100,      32'd7,        32'd14,       4'b0000, 0, 0, 36);
        vecs[1] = mk(SDIVCC, 32'hffffffff, 32'hffffff9c, 32'd7,        32'hfffffff2, 4'b1000, 1, 0, 36);
        vecs[2] = mk(UDIVCC, 32'h1,        32'h0,        32'd1,        32'hffffffff, 4'b1010, 1, 0, 4);
        vecs[3] = mk(SDIV,   32'h0,        32'd5,        32'h0,        32'h0,        4'b0000, 0, 1, 4);
        vecs[4] = mk(SDIV,   32'hffffffff, 32'h80000000, 32'd1,        32'h80000000, 4'b1000, 0, 0, 36);
        vecs[5] = mk(SDIVCC, 32'h0,        32'h80000000, 32'd1,        32'h7fffffff, 4'b0010, 1, 0, 36);
        vecs[6] = mk(UDIVCC, 32'h0,        32'h0,        32'd5,        32'h0,        4'b0100, 1, 0, 36);
        vecs[7] = mk(SDIVCC, 32'hffffffff, 32'hfffffffd, 32'd7,        32'h0,        4'b0100, 1, 0, 36);
        vecs[8] = mk(SDIVCC, 32'h80000000, 32'h0,        32'hffffffff, 32'h7fffffff, 4'b0010, 1, 0, 4);
        vecs[9] = mk(UDIV,   32'hfffffffe, 32'hffffffff, 32'hffffffff, 32'hffffffff, 4'b1000, 0, 0, 36);

        rstn = 1'b0; req_valid = 1'b0; req_tid = '0; req_op3 = '0; req_y = '0;
        req_rs1 = '0; req_op2 = '0; flush = 1'b0; flush_tid = '0; resp_ready = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge gclk);
        #1;
        check("rst.req_ready",   64'(req_ready),   64'd1);
        check("rst.resp_valid",  64'(resp_valid),  64'd0);
        check("rst.busy",        64'(busy),        64'd0);
        check("rst.resp_result", 64'(resp_result), 64'd0);
        check("rst.resp_icc",    64'(resp_icc),    64'd0);
        check("rst.resp_tt",     64'(resp_tt),     64'd0);
        @(negedge gclk);
        rstn = 1'b1;

        // ---- directed table ----
        for (int i = 0; i < 10; i++) begin
            send(i + 10, vecs[i].op3, vecs[i].y, vecs[i].rs1, vecs[i].op2, acc);
            wait_resp($sformatf("vec%0d", i), seen, got);
            if (got) begin
                check($sformatf("vec%0d.latency", i), 64'(seen - acc + 1), 64'(vecs[i].e.lat));
                check_resp($sformatf("vec%0d", i), i + 10, vecs[i].e);
                handshake(hs);
            end
        end

        // ---- back-to-back, held response, ordering ----
        send(1, UDIV,   32'h0, 32'd1000, 32'd10, acc);
        send(2, SDIVCC, 32'h0, 32'd9,    32'h0,  hs);
        send(3, UDIVCC, 32'h0, 32'd77,   32'd7,  hs);
        wait_resp("b2b.t1", seen, got);
        if (got) begin
            check("b2b.t1.latency", 64'(seen - acc + 1), 64'd36);
            for (int k = 0; k < 5; k++) begin
                check_resp($sformatf("b2b.t1.hold%0d", k), 1, model(UDIV, 32'h0, 32'd1000, 32'd10));
                @(negedge gclk);
            end
            handshake(hs);
            wait_resp("b2b.t2", seen, got);
            if (got) begin
                check("b2b.t2.latency", 64'(seen - hs + 1), 64'd3);
                check_resp("b2b.t2", 2, model(SDIVCC, 32'h0, 32'd9, 32'h0));
                handshake(hs);
                wait_resp("b2b.t3", seen, got);
                if (got) begin
                    check("b2b.t3.latency", 64'(seen - hs + 1), 64'd35);
                    check_resp("b2b.t3", 3, model(UDIVCC, 32'h0, 32'd77, 32'd7));
                    handshake(hs);
                end
            end
        end

        // ---- flush in-flight tid 3 and queued tid 5 ----
        send(3, UDIV,   32'h0, 32'd500,   32'd5,  acc);
        send(5, UDIV,   32'h0, 32'd600,   32'd6,  hs);
        send(6, UDIVCC, 32'h0, 32'd12345, 32'd11, hs);
        repeat (8) @(negedge gclk);
        flush = 1'b1; flush_tid = TIDW'(5);
        @(negedge gclk);
        flush_tid = TIDW'(3);
        @(negedge gclk);
        flush = 1'b0;
        wait_resp("flush.t6", seen, got);
        if (got) begin
            check_resp("flush.t6", 6, model(UDIVCC, 32'h0, 32'd12345, 32'd11));
            handshake(hs);
            @(negedge gclk);
            check("flush.busy_after", 64'(busy), 64'd0);
        end

        // ---- request killed in its accept cycle ----
        @(negedge gclk);
        req_tid = TIDW'(7); req_op3 = UDIV; req_y = 32'h0; req_rs1 = 32'd50; req_op2 = 32'd5;
        req_valid = 1'b1; flush = 1'b1; flush_tid = TIDW'(7);
        @(posedge gclk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        nvalid = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge gclk);
            if (resp_valid) nvalid++;
        end
        check("drop.resp_count", 64'(nvalid), 64'd0);
        check("drop.busy", 64'(busy), 64'd0);

        // ---- non-divide opcode is ignored ----
        send(9, 6'h0a, 32'h0, 32'd10, 32'd2, acc);
        @(negedge gclk);
        check("badop.busy", 64'(busy), 64'd0);

        // ---- reset mid-ITER ----
        send(4, UDIV, 32'h0, 32'd99, 32'd3, acc);
        repeat (10) @(negedge gclk);
        #2 rstn = 1'b0;
        #1;
        check("rst_iter.resp_valid", 64'(resp_valid), 64'd0);
        check("rst_iter.busy",       64'(busy),       64'd0);
        check("rst_iter.req_ready",  64'(req_ready),  64'd1);
        @(negedge gclk);
        rstn = 1'b1;

        // ---- reset while a response is pending ----
        send(4, UDIV, 32'h0, 32'd99, 32'd3, acc);
        wait_resp("rst_done", seen, got);
        if (got) begin
            #2 rstn = 1'b0;
            #1;
            check("rst_done.resp_valid",  64'(resp_valid),  64'd0);
            check("rst_done.resp_result", 64'(resp_result), 64'd0);
            check("rst_done.busy",        64'(busy),        64'd0);
            @(negedge gclk);
            rstn = 1'b1;
        end

        // ---- randomized against the reference model ----
        for (int i = 0; i < 40; i++) begin
            op3 = ops[$urandom_range(0, 3)];
            rs1 = $urandom;
            case ($urandom_range(0, 3))
                0:       y = $urandom;
                1:       y = 32'h0;
                default: y = {32{rs1[31]}};
            endcase
            case ($urandom_range(0, 7))
                0:       op2 = 32'h0;
                1:       op2 = 32'($urandom_range(1, 15));
                2:       op2 = 32'hffff_fff0 | 32'($urandom_range(0, 15));
                default: op2 = $urandom;
            endcase
            tid = $urandom_range(0, NTHREAD - 1);
            e   = model(op3, y, rs1, op2);
            send(tid, op3, y, rs1, op2, acc);
            wait_resp($sformatf("rnd%0d", i), seen, got);
            if (got) begin
                check($sformatf("rnd%0d.latency", i), 64'(seen - acc + 1), 64'(e.lat));
                repeat ($urandom_range(0, 2)) @(negedge gclk);
                check_resp($sformatf("rnd%0d", i), tid, e);
                handshake(hs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Shared iterative integer-divide sequencer for the multithreaded integer pipeline. It accepts UDIV/SDIV/UDIVCC/SDIVCC requests from the execute stage, one per cycle at most, and queues them per thread. It runs them one at a time through a 32-step radix-2 restoring divider and returns the quotient, icc and divide-by-zero status to writeback under a valid/ready handshake.

## Interface
- NTHREAD, 64: hardware threads; FIFO depth; TID width = $clog2(NTHREAD)
- gclk  in  1  clock
- rstn  in  1  reset; asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_tid  in  TIDW  issuing thread
- req_op3  in  6  one of UDIV, SDIV, UDIVCC, SDIVCC
- req_y  in  32  Y register, dividend high
- req_rs1  in  32  dividend low
- req_op2  in  32  divisor
- flush  in  1  kill pending and in-flight work of flush_tid
- flush_tid  in  TIDW  thread to kill
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts
- resp_tid  out  TIDW  owning thread
- resp_result  out  32  quotient, after saturation
- resp_icc  out  4  {N,Z,V,C}
- resp_icc_we  out  1  1 for the CC variants only
- resp_trap  out  1  divide by zero
- resp_tt  out  6  TT_DIVZ when resp_trap is 1, else 0
- busy  out  1  FSM not IDLE, or FIFO non-empty

## Operation
- FIFO
  - A request is accepted when req_valid and req_ready are both 1. Accepted requests enter the FIFO in order.
  - An op3 outside the four divide codes is ignored.
- FSM states and transitions
  - IDLE: if the FIFO head is live, pop it and load operands, then go to SETUP. Dead heads are popped and discarded with no state change.
  - SETUP, divisor == 0: go to FIX with trap set.
  - SETUP, signed op: take the magnitudes of the 64-bit dividend and the divisor. Record the result sign as dividend[63] ^ divisor[31].
  - SETUP, overflow: if the dividend high magnitude >= the divisor magnitude, set ovf and go to FIX.
  - SETUP, otherwise: go to ITER with the counter at 31.
  - ITER: one restoring step per cycle: shift {rem, q}, trial-subtract, set the q bit. Leave after the counter = 0 step, going to FIX.
  - FIX: apply the sign and saturation, then go to DONE.
  - DONE: resp_valid = 1 and outputs stable. On resp_ready, go to SETUP with the head loaded if the FIFO head is live, else go to IDLE.
- Saturation
  - Unsigned overflow gives 0xFFFFFFFF with V = 1.
  - Signed, magnitude quotient q:
    - Negative result and q > 2^31, or ovf: 0x80000000, V = 1.
    - Positive result and q > 2^31-1, or ovf: 0x7FFFFFFF, V = 1.
    - Otherwise the two's-complement result.
- Flags
  - N = result[31]; Z = (result == 0); C = 0 always.
  - On trap: result = 0, icc_we = 0.
- Flush
  - FIFO entries whose tid matches flush_tid are marked dead in the same cycle.
  - If the in-flight op belongs to flush_tid (SETUP/ITER/FIX/DONE), the FSM goes to IDLE next cycle and no response is issued.
  - A request accepted in the same cycle as a flush of its tid is dropped.
- Reset (any time, including mid-operation)
  - FIFO empty, FSM IDLE.
  - All outputs 0, except req_ready = 1.

## Timing
- Accept at cycle t0, with the FIFO empty and the FSM idle:
  - IDLE pop at t0+1.
  - SETUP at t0+2.
  - ITER at t0+3..t0+34.
  - FIX at t0+35.
  - resp_valid at t0+36.
- Divide-by-zero or overflow: resp_valid at t0+4.
- Back-to-back: DONE with resp_ready at cycle t puts the next op in SETUP at t+1.
- resp_* outputs are registered and held while resp_valid & !resp_ready.
- Simultaneous push and pop on a full FIFO: the push is refused; req_ready is derived from registered count.
- The pipeline guarantees at most one outstanding divide per tid. Depth NTHREAD therefore never fills in normal operation.

## Structure
- libopcodes, shared (existing): UDIV, SDIV, UDIVCC, SDIVCC, TT_DIVZ.
- New shared iu package entries:
  - div_req_type struct: tid, op3, y, rs1, op2, live.
  - div_state_type enum: IDLE, SETUP, ITER, FIX, DONE.
  - div_resp_type struct.
- Sub-module div_req_fifo: circular buffer with per-entry live bits, a tid-match kill port, and head/tail/count pointers that wrap at NTHREAD.

## Test plan
- UDIV y=0, rs1=100, op2=7: result 14, icc 0000, response at t0+36.
- SDIVCC y=0xFFFFFFFF, rs1=0xFFFFFF9C (-100), op2=7: result 0xFFFFFFF2, icc 1000, icc_we 1.
- UDIVCC y=1, rs1=0, op2=1: overflow, result 0xFFFFFFFF, icc 1010, response at t0+4.
- SDIV with op2=0: resp_trap 1, resp_tt 0x2A, result 0, icc_we 0.
- Three tids back-to-back with resp_ready low for 5 cycles: responses come in FIFO order, held stable, and the next SETUP follows the cycle after the handshake.
- Flush tid 3 while it is in ITER, and flush tid 5 while it is queued: neither responds and tid 6 completes next. Separately, drive rstn low mid-ITER: resp_valid goes to 0 immediately and busy reads 0 after reset.
